from8bit_packer: RTL and testbench
==================================

Name: from8bit_packer

Overview:
- Receive-side counterpart of the 8-bit serialiser: reassembles a byte stream into 8-, 16- or 32-bit words, selected by dataS.
- Runs on the single base-rate clock. Byte lanes are tracked with an internal counter instead of divided clocks.
- Sits after the 8-bit link. Delivers one registered word plus a one-cycle valid strobe per completed word.

Parameters:
- RST_VAL, 32'h0000_0000: value loaded into dataOut on reset.
- HOLD_OUT, 1: 1 = dataOut holds the last word between strobes; 0 = dataOut returns to 0 in every cycle where validOut is 0.

Ports:
- clk  input  1  base-rate clock, one byte slot per cycle
- rst  input  1  asynchronous reset, active-high
- enb  input  1  block enable; when 0, all state freezes
- validIn  input  1  dataIn carries a byte this cycle
- sof  input  1  start of word; the byte accepted this cycle is byte 0
- dataIn  input  8  incoming byte
- dataS  input  2  mode: 00/11 = 8-bit, 01 = 16-bit, 10 = 32-bit
- dataOut  output  32  assembled word, zero-extended in 8/16-bit modes
- validOut  output  1  one-cycle strobe: dataOut holds a new word
- errOut  output  1  misalignment strobe (only when FROM8BIT_ERR_EN is defined; otherwise tied to 0)

Behaviour:
- Reset (async, rst=1): lane counter 0, assembly register 0, mode register 2'b00, dataOut = RST_VAL, validOut 0, errOut 0.
- Bytes per word N: 1 for 8-bit mode, 2 for 16-bit, 4 for 32-bit.
- Accept condition: enb && validIn on a rising clk edge.
- Lane order: the first accepted byte goes to [7:0], the second to [15:8], the third to [23:16], the fourth to [31:24].
- Lane counter:
  - Increments by 1 on each accepted byte.
  - Wraps to 0 after lane N-1.
  - Unchanged when no byte is accepted.
- sof:
  - Acts only on an accepted byte.
  - Forces that byte into lane 0 and drops any partial word. The counter becomes 1, or stays 0 if N=1.
  - sof with validIn=0 is ignored.
- Completion:
  - When the accepted byte lands in lane N-1, dataOut is registered on the same edge and validOut=1 for exactly that following cycle.
  - Latency: 1 clk from the last byte's edge to the strobe.
  - Unused upper bits are 0.
- Throughput: one byte per cycle, back-to-back words allowed. In 8-bit mode validOut may stay high on consecutive cycles.
- Mode change:
  - dataS is compared against the mode register every cycle.
  - On a difference: the partial word is dropped, the counter is cleared, and the mode register is updated.
  - A byte accepted in that same cycle is treated as lane 0 of the new mode.
  - Mode changes are tracked even while enb=0.
- enb=0:
  - Counter and assembly register hold; nothing is accepted.
  - validOut is 0 from the next cycle on.
  - dataOut follows HOLD_OUT.
- Partial words are never emitted. A reset in the middle of a word discards the partial.
- Simultaneous sof and mode change: the mode change applies and the byte goes to lane 0. Only one restart occurs.

Optional Feature:
- Macro: FROM8BIT_ERR_EN.
- Defined: errOut pulses high for 1 cycle (registered, same timing as validOut) when either:
  - an accepted byte carries sof while the counter is non-zero (a partial word is dropped), or
  - a mode change drops a non-empty partial word.
- Not defined: errOut is constant 0 and no error logic is synthesised.

Test Plan:
- Reset/8-bit: rst pulse with RST_VAL=0, then dataS=00 and bytes 0xA5, 0x3C back-to-back → dataOut=0x000000A5 then 0x0000003C, validOut high 2 consecutive cycles, 1 clk after each byte.
- 16-bit: dataS=01, sof+0x34, then 0x12 → one strobe, dataOut=0x00001234. Between the bytes validOut=0.
- 32-bit with gaps: dataS=10, bytes 0x78 (sof), idle, 0x56, enb=0 for 3 cycles, 0x34, 0x12 → single strobe, dataOut=0x12345678. State frozen during the gaps.
- Realign: dataS=10, bytes 0x11 (sof), 0x22, then 0xAA (sof), 0xBB, 0xCC, 0xDD → only word 0xDDCCBBAA emitted. errOut=1 for 1 cycle at the second sof when FROM8BIT_ERR_EN is defined, else 0.
- Mode change mid-word: dataS=10, bytes 0x01, 0x02, then dataS=01 with byte 0xEF, then 0xBE → dataOut=0x0000BEEF, no 32-bit word emitted.
- Async reset mid-word: dataS=01, byte 0x55, assert rst between clock edges → outputs clear immediately. After release, bytes 0x66, 0x77 → dataOut=0x00007766.

Source files
------------

// File: rtl/from8bit_packer.sv
// Reassembles an 8-bit byte stream into 8/16/32-bit words selected by dataS.
// Define FROM8BIT_ERR_EN to get the misalignment strobe on errOut.
module from8bit_packer #(
  parameter logic [31:0] RST_VAL  = 32'h0000_0000,
  parameter bit          HOLD_OUT = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enb,
  input  logic        validIn,
  input  logic        sof,
  input  logic [7:0]  dataIn,
  input  logic [1:0]  dataS,
  output logic [31:0] dataOut,
  output logic        validOut,
  output logic        errOut
);

  logic [1:0]  mode_q, mode_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] data_q, data_d;
  logic        valid_q, valid_d;

  logic        mode_chg, accept, restart, complete;
  logic [1:0]  last_lane, lane;
  logic [31:0] base, word;

  always_comb begin
    mode_chg = (dataS != mode_q);
    accept   = enb & validIn;
    // A mode change and an accepted sof share one restart path.
    restart  = mode_chg | (accept & sof);

    unique case (dataS)
      2'b01:   last_lane = 2'd1;
      2'b10:   last_lane = 2'd3;
      default: last_lane = 2'd0;
    endcase

    lane     = restart ? 2'd0 : cnt_q;
    base     = restart ? 32'd0 : asm_q;
    word     = base | ({24'd0, dataIn} << {lane, 3'b000});
    complete = accept & (lane == last_lane);

    mode_d = dataS;
    cnt_d  = cnt_q;
    asm_d  = asm_q;
    if (accept) begin
      if (complete) begin
        cnt_d = 2'd0;
        asm_d = 32'd0;
      end else begin
        cnt_d = 2'(lane + 2'd1);
        asm_d = word;
      end
    end else if (mode_chg) begin
      cnt_d = 2'd0;
      asm_d = 32'd0;
    end

    valid_d = complete;
    if (complete) begin
      data_d = word;
    end else if (HOLD_OUT) begin
      data_d = data_q;
    end else begin
      data_d = 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= 2'b00;
      cnt_q   <= 2'd0;
      asm_q   <= 32'd0;
      data_q  <= RST_VAL;
      valid_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign dataOut  = data_q;
  assign validOut = valid_q;

`ifdef FROM8BIT_ERR_EN
  logic err_q, err_d;

  // Any restart while bytes are pending throws away a partial word.
  assign err_d = restart & (cnt_q != 2'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign errOut = err_q;
`else
  assign errOut = 1'b0;
`endif

endmodule

// File: tb/tb_from8bit_packer.sv
// Directed bench for from8bit_packer: queue-based word model compared every cycle,
// plus literal expectations for each scenario.
module tb_from8bit_packer;

  localparam logic [31:0] RST_V = 32'h0000_0000;
  localparam bit          HOLD  = 1'b1;
`ifdef FROM8BIT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enb = 1'b0;
  logic        validIn = 1'b0;
  logic        sof = 1'b0;
  logic [7:0]  dataIn = 8'd0;
  logic [1:0]  dataS = 2'b00;
  logic [31:0] dataOut;
  logic        validOut;
  logic        errOut;

  from8bit_packer #(
    .RST_VAL  (RST_V),
    .HOLD_OUT (HOLD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enb      (enb),
    .validIn  (validIn),
    .sof      (sof),
    .dataIn   (dataIn),
    .dataS    (dataS),
    .dataOut  (dataOut),
    .validOut (validOut),
    .errOut   (errOut)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Model: pending bytes of the current word, emitted once N have arrived.
  logic [7:0]  pend[$];
  logic [1:0]  m_mode;
  logic [31:0] exp_data;
  logic        exp_valid, exp_err;
  logic        m_drop, m_done;
  logic [31:0] m_word;
  int          m_n;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
      m_mode    = 2'b00;
      exp_data  <= RST_V;
      exp_valid <= 1'b0;
      exp_err   <= 1'b0;
    end else begin
      m_drop = 1'b0;
      m_done = 1'b0;
      m_word = 32'd0;
      if (dataS != m_mode) begin
        m_drop = (pend.size() > 0);
        pend.delete();
        m_mode = dataS;
      end
      if (enb && validIn) begin
        if (sof) begin
          if (pend.size() > 0) m_drop = 1'b1;
          pend.delete();
        end
        pend.push_back(dataIn);
        m_n = (m_mode == 2'b01) ? 2 : (m_mode == 2'b10) ? 4 : 1;
        if (pend.size() == m_n) begin
          for (int i = 0; i < m_n; i++) m_word = m_word + (32'(pend[i]) << (8 * i));
          m_done = 1'b1;
          pend.delete();
        end
      end
      exp_valid <= m_done;
      exp_data  <= m_done ? m_word : (HOLD ? exp_data : 32'd0);
      exp_err   <= ERR_EN && m_drop;
    end
  end

  logic [31:0] got[$];

  always @(negedge clk) begin
    if (!rst) begin
      chk("dataOut", dataOut, exp_data);
      chk("validOut", 32'(validOut), 32'(exp_valid));
      chk("errOut", 32'(errOut), 32'(exp_err));
      if (validOut) got.push_back(dataOut);
    end
  end

  task automatic drv(input logic e, input logic v, input logic s, input logic [1:0] m,
                     input logic [7:0] d);
    enb = e; validIn = v; sof = s; dataS = m; dataIn = d;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input logic [1:0] m);
    drv(1'b1, 1'b0, 1'b0, m, 8'h00);
  endtask

  task automatic chk_got(input string name, input logic [31:0] w0, input int n);
    chk({name, "_count"}, 32'(got.size()), 32'(n));
    if (got.size() > 0) chk({name, "_word"}, got[0], w0);
    got.delete();
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;
    chk("rst_dataOut", dataOut, 32'h0000_0000);
    chk("rst_validOut", 32'(validOut), 32'd0);
    idle(2'b00);

    // 8-bit back-to-back
    got.delete();
    drv(1'b1, 1'b1, 1'b0, 2'b00, 8'hA5);
    chk("b8_first", dataOut, 32'h0000_00A5);
    chk("b8_v1", 32'(validOut), 32'd1);
    drv(1'b1, 1'b1, 1'b0, 2'b00, 8'h3C);
    chk("b8_second", dataOut, 32'h0000_003C);
    chk("b8_v2", 32'(validOut), 32'd1);
    idle(2'b00);
    chk("b8_count", 32'(got.size()), 32'd2);
    got.delete();

    // 16-bit with mode change and sof on the same byte
    drv(1'b1, 1'b1, 1'b1, 2'b01, 8'h34);
    chk("w16_gap", 32'(validOut), 32'd0);
    drv(1'b1, 1'b1, 1'b0, 2'b01, 8'h12);
    idle(2'b01);
    chk_got("w16", 32'h0000_1234, 1);

    // 32-bit with idle and enb gaps; gated bytes must be ignored
    drv(1'b1, 1'b1, 1'b1, 2'b10, 8'h78);
    idle(2'b10);
    drv(1'b1, 1'b1, 1'b0, 2'b10, 8'h56);
    repeat (3) drv(1'b0, 1'b1, 1'b0, 2'b10, 8'hFF);
    drv(1'b1, 1'b1, 1'b0, 2'b10, 8'h34);
    drv(1'b1, 1'b1, 1'b0, 2'b10, 8'h12);
    idle(2'b10);
    chk_got("w32gap", 32'h1234_5678, 1);

    // Realign with sof mid-word
    drv(1'b1, 1'b1, 1'b1, 2'b10, 8'h11);
    drv(1'b1, 1'b1, 1'b0, 2'b10, 8'h22);
    drv(1'b1, 1'b1, 1'b1, 2'b10, 8'hAA);
    chk("realign_err", 32'(errOut), 32'(ERR_EN));
    drv(1'b1, 1'b1, 1'b0, 2'b10, 8'hBB);
    chk("realign_err_clr", 32'(errOut), 32'd0);
    drv(1'b1, 1'b1, 1'b0, 2'b10, 8'hCC);
    drv(1'b1, 1'b1, 1'b0, 2'b10, 8'hDD);
    idle(2'b10);
    chk_got("realign", 32'hDDCC_BBAA, 1);

    // Mode change drops a 32-bit partial
    drv(1'b1, 1'b1, 1'b0, 2'b10, 8'h01);
    drv(1'b1, 1'b1, 1'b0, 2'b10, 8'h02);
    drv(1'b1, 1'b1, 1'b0, 2'b01, 8'hEF);
    chk("modechg_err", 32'(errOut), 32'(ERR_EN));
    drv(1'b1, 1'b1, 1'b0, 2'b01, 8'hBE);
    idle(2'b01);
    chk_got("modechg", 32'h0000_BEEF, 1);

    // Async reset mid-word
    drv(1'b1, 1'b1, 1'b0, 2'b01, 8'h55);
    chk("pre_rst_hold", dataOut, 32'h0000_BEEF);
    rst = 1'b1;
    #1;
    chk("arst_dataOut", dataOut, RST_V);
    chk("arst_validOut", 32'(validOut), 32'd0);
    chk("arst_errOut", 32'(errOut), 32'd0);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    drv(1'b1, 1'b1, 1'b0, 2'b01, 8'h66);
    drv(1'b1, 1'b1, 1'b0, 2'b01, 8'h77);
    idle(2'b01);
    chk_got("after_rst", 32'h0000_7766, 1);

    // Mode 11 behaves as 8-bit
    drv(1'b1, 1'b1, 1'b0, 2'b11, 8'h9A);
    idle(2'b11);
    chk_got("mode11", 32'h0000_009A, 1);

    repeat (2) idle(2'b11);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
